pipelined_adder_tree: RTL and testbench
=======================================

Name: pipelined_adder_tree

Overview:
- Parametrised, fully pipelined 2^LEVELS-input adder tree. It generalises the fixed 2-level, 8-bit, unregistered-branch tree.
- Adds the following over that tree:
  - a register after every tree level;
  - a valid/ready handshake with backpressure;
  - signed/unsigned operation;
  - an optional accumulate mode that sums successive beats up to a framing "last" marker.
- Sits in the arithmetic benchmark set as the generator target for adder-tree circuits of any width and depth.

Parameters:
- WIDTH, 8, bit width of each input operand.
- LEVELS, 3, tree depth. N_IN = 2^LEVELS inputs. Legal range 1..6.
- SIGNED, 0, 1 = operands two's-complement and sign-extended; 0 = zero-extended.
- ACCUMULATE, 0, 1 = accumulate tree sums across beats until in_last.
- ACC_BITS, 8, extra accumulator headroom bits. Ignored when ACCUMULATE=0.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_data, input, N_IN*WIDTH, packed operands. Operand k is bits [k*WIDTH +: WIDTH].
- in_valid, input, 1, in_data/in_last valid this cycle.
- in_last, input, 1, marks the final beat of an accumulation frame. Ignored if ACCUMULATE=0.
- in_ready, output, 1, block accepts a beat this cycle.
- out_data, output, OUT_W, result. OUT_W = WIDTH+LEVELS, plus ACC_BITS if ACCUMULATE=1.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts the result.

Behaviour:
- Reset (asynchronous, rst=1):
  - all pipeline valid bits, out_valid, out_data and the accumulator clear to 0 immediately;
  - in_ready = 1 while rst is deasserted and the pipeline is not stalled.
  - Reset mid-operation discards all in-flight beats and any partial accumulation. No output is produced for them.
- Pipeline:
  - Stage 0 registers the operands.
  - Stage L (1..LEVELS) registers the 2^(LEVELS-L) pairwise sums of stage L-1. Each level widens by 1 bit (width WIDTH+L).
  - Extension is sign or zero per SIGNED. No overflow is possible.
  - Each stage carries a valid bit and a last bit.
- Global stall:
  - adv = ~out_valid | out_ready. All stages and the accumulator update only when adv=1.
  - in_ready = adv. A beat is accepted when in_valid & in_ready.
  - Bubbles (valid=0) propagate without being squeezed. Throughput is 1 beat/cycle when out_ready=1.
- Latency with out_ready held 1:
  - ACCUMULATE=0: out_valid asserts LEVELS+1 cycles after acceptance. out_data = sum of N_IN operands, extended to OUT_W.
  - ACCUMULATE=1: one extra accumulator stage, so LEVELS+2 cycles from acceptance of the last beat.
- Accumulate mode:
  - acc <= (frame_start ? 0 : acc) + tree_sum on each valid tree output. frame_start is 1 after reset and after each emitted last.
  - On a valid tree output with last=1, out_data = acc + tree_sum, out_valid=1, and the accumulator restarts.
  - Non-last beats produce no output.
  - Accumulator wraps modulo 2^OUT_W on overflow. No saturation and no flag.
  - A single-beat frame (in_last on the first beat) outputs that beat's sum.
- Output hold:
  - While out_valid=1 and out_ready=0, out_data is held stable and the pipeline freezes.
  - out_valid drops the cycle after the handshake unless a new result advances into the output stage that same cycle.
- out_data while out_valid=0 holds its last value (0 after reset). The bench must not check it in that state.

Decomposition:
- Package pipelined_adder_tree_pkg holds:
  - function n_in(levels) = 1<<levels;
  - function out_w(width, levels, accumulate, acc_bits);
  - a localparam guard range for LEVELS.
- Sub-module adder_tree_level (parameters: IN_W, N_PAIRS, SIGNED):
  - one registered pairwise-add level with valid/last pass-through and an enable input;
  - instantiated LEVELS times in a generate loop.
- The accumulator and output register live in the top module.

Test Plan:
- WIDTH=8, LEVELS=3, SIGNED=0, ACC=0: all operands 8'hFF, one beat -> out_data=11'd2040, out_valid exactly 4 cycles after acceptance.
- SIGNED=1, same size: operands 8'h80 (-128) x8 -> out_data=11'h400 (-1024). Operands alternating +127/-128 -> -4 (11'h7FC).
- Back-to-back 16 beats of random data with out_ready=1 -> one result per cycle, in order, matching the reference model sum. in_ready constantly 1.
- Backpressure: out_ready=0 for 5 cycles while beats stream in -> in_ready=0 after the output fills, out_data stable, no beat lost or duplicated after release.
- ACCUMULATE=1, ACC_BITS=8: three beats with all operands 1, 2, 3 and last on the third -> single output 48, 5 cycles after the last beat. Then a single-beat frame of all 1 -> 8.
- Assert rst mid-frame after 2 accumulate beats -> outputs clear asynchronously. The next frame (beats of all 1, last on the 2nd) -> 16, with no residue from the aborted frame.

Source files
------------

// File: rtl/pipelined_adder_tree_pkg.sv
// Sizing helpers, legal depth range and per-stage sideband for the pipelined adder tree.
// Pure declarations, no logic: shared by the tree levels and the top.
package pipelined_adder_tree_pkg;

   localparam int LEVELS_MIN = 1;
   localparam int LEVELS_MAX = 6;

   typedef struct packed {
      logic vld;
      logic last;
   } meta_t;

   function automatic int n_in(input int levels);
      return 1 << levels;
   endfunction

   function automatic int out_w(input int width, input int levels,
                                input int accumulate, input int acc_bits);
      return width + levels + ((accumulate != 0) ? acc_bits : 0);
   endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise-add tree level, 1 cycle; valid/last ride alongside the sums.
// Holds everything while en=0, so the global stall freezes the level in place.
module adder_tree_level
   import pipelined_adder_tree_pkg::*;
#(
   parameter int IN_W    = 8,
   parameter int N_PAIRS = 4,
   parameter int SIGNED  = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [2*N_PAIRS*IN_W-1:0]   in_dat,
   input  meta_t                       in_meta,
   output logic [N_PAIRS*(IN_W+1)-1:0] out_dat,
   output meta_t                       out_meta
);

   localparam int SUM_W = IN_W + 1;

   logic [N_PAIRS*SUM_W-1:0] sum_dat;

   for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
      logic [IN_W-1:0]  a;
      logic [IN_W-1:0]  b;
      logic [SUM_W-1:0] a_ext;
      logic [SUM_W-1:0] b_ext;

      assign a = in_dat[(2*p)*IN_W +: IN_W];
      assign b = in_dat[(2*p+1)*IN_W +: IN_W];
      // One extra bit per level is enough: the sum of two IN_W values never overflows it.
      assign a_ext = {(SIGNED != 0) & a[IN_W-1], a};
      assign b_ext = {(SIGNED != 0) & b[IN_W-1], b};
      assign sum_dat[p*SUM_W +: SUM_W] = a_ext + b_ext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_dat  <= '0;
         out_meta <= '0;
      end else if (en) begin
         out_dat  <= sum_dat;
         out_meta <= in_meta;
      end
   end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined 2^LEVELS-input adder tree, optional frame accumulation; latency LEVELS+1 (+1 when accumulating).
// Single global stall: every stage advances only when the output register is empty or being drained.
module pipelined_adder_tree
   import pipelined_adder_tree_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int LEVELS     = 3,
   parameter int SIGNED     = 0,
   parameter int ACCUMULATE = 0,
   parameter int ACC_BITS   = 8
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [n_in(LEVELS)*WIDTH-1:0]                     in_data,
   input  logic                                              in_valid,
   input  logic                                              in_last,
   output logic                                              in_ready,
   output logic [out_w(WIDTH,LEVELS,ACCUMULATE,ACC_BITS)-1:0] out_data,
   output logic                                              out_valid,
   input  logic                                              out_ready
);

   localparam int N_IN  = n_in(LEVELS);
   localparam int SUM_W = WIDTH + LEVELS;
   localparam int OUT_W = out_w(WIDTH, LEVELS, ACCUMULATE, ACC_BITS);

   if (LEVELS < LEVELS_MIN || LEVELS > LEVELS_MAX) begin : g_bad_levels
      $error("pipelined_adder_tree: LEVELS out of supported range");
   end

   logic              adv;
   logic [N_IN*WIDTH-1:0] s0_dat;
   meta_t             s0_meta;
   logic [SUM_W-1:0]  tree_dat;
   meta_t             tree_meta;
   logic [OUT_W-1:0]  tree_ext;
   logic [OUT_W-1:0]  res_dat;
   logic              res_vld;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Stage 0: operand register; a beat is accepted exactly when it is captured here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_dat  <= '0;
         s0_meta <= '0;
      end else if (adv) begin
         s0_dat  <= in_data;
         s0_meta <= '{vld: in_valid, last: in_last && (ACCUMULATE != 0)};
      end
   end

   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int IN_W = WIDTH + l - 1;
      localparam int NP   = N_IN >> l;

      logic [2*NP*IN_W-1:0]   src_dat;
      meta_t                  src_meta;
      logic [NP*(IN_W+1)-1:0] dst_dat;
      meta_t                  dst_meta;

      if (l == 1) begin : g_first
         assign src_dat  = s0_dat;
         assign src_meta = s0_meta;
      end else begin : g_next
         assign src_dat  = g_lvl[l-1].dst_dat;
         assign src_meta = g_lvl[l-1].dst_meta;
      end

      adder_tree_level #(
         .IN_W    (IN_W),
         .N_PAIRS (NP),
         .SIGNED  (SIGNED)
      ) u_level (
         .clk      (clk),
         .rst      (rst),
         .en       (adv),
         .in_dat   (src_dat),
         .in_meta  (src_meta),
         .out_dat  (dst_dat),
         .out_meta (dst_meta)
      );
   end

   assign tree_dat  = g_lvl[LEVELS].dst_dat;
   assign tree_meta = g_lvl[LEVELS].dst_meta;

   if (SIGNED != 0) begin : g_ext_s
      assign tree_ext = OUT_W'($signed(tree_dat));
   end else begin : g_ext_u
      assign tree_ext = OUT_W'(tree_dat);
   end

   if (ACCUMULATE != 0) begin : g_acc
      logic [OUT_W-1:0] acc_dat;
      logic             acc_done;
      logic             frame_start;

      // acc_done flags that acc_dat holds a finished frame; the output stage takes it
      // on the same edge that a following beat may already restart the accumulator.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc_dat     <= '0;
            acc_done    <= 1'b0;
            frame_start <= 1'b1;
         end else if (adv) begin
            acc_done <= tree_meta.vld & tree_meta.last;
            if (tree_meta.vld) begin
               acc_dat     <= (frame_start ? '0 : acc_dat) + tree_ext;
               frame_start <= tree_meta.last;
            end
         end
      end

      assign res_dat = acc_dat;
      assign res_vld = acc_done;
   end else begin : g_noacc
      logic unused_last;

      assign unused_last = tree_meta.last;
      assign res_dat     = tree_ext;
      assign res_vld     = tree_meta.vld;
   end

   // Output register: data only moves with a valid result so it holds across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         out_valid <= res_vld;
         if (res_vld) begin
            out_data <= res_dat;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: unsigned, signed and accumulating instances checked
// against arithmetic reference sums of the driven operands.
module tb_pipelined_adder_tree;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // unsigned, no accumulate
   logic [63:0] u_data;
   logic        u_valid, u_last, u_ready, u_ovalid, u_oready;
   logic [10:0] u_out;
   // signed, no accumulate
   logic [63:0] s_data;
   logic        s_valid, s_last, s_ready, s_ovalid, s_oready;
   logic [10:0] s_out;
   // unsigned, accumulate
   logic [63:0] a_data;
   logic        a_valid, a_last, a_ready, a_ovalid, a_oready;
   logic [18:0] a_out;

   pipelined_adder_tree #(.WIDTH(8), .LEVELS(3), .SIGNED(0), .ACCUMULATE(0), .ACC_BITS(8)) dut_u (
      .clk(clk), .rst(rst), .in_data(u_data), .in_valid(u_valid), .in_last(u_last),
      .in_ready(u_ready), .out_data(u_out), .out_valid(u_ovalid), .out_ready(u_oready));

   pipelined_adder_tree #(.WIDTH(8), .LEVELS(3), .SIGNED(1), .ACCUMULATE(0), .ACC_BITS(8)) dut_s (
      .clk(clk), .rst(rst), .in_data(s_data), .in_valid(s_valid), .in_last(s_last),
      .in_ready(s_ready), .out_data(s_out), .out_valid(s_ovalid), .out_ready(s_oready));

   pipelined_adder_tree #(.WIDTH(8), .LEVELS(3), .SIGNED(0), .ACCUMULATE(1), .ACC_BITS(8)) dut_a (
      .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
      .in_ready(a_ready), .out_data(a_out), .out_valid(a_ovalid), .out_ready(a_oready));

   // Handshake logs: a result is consumed at the posedge following a negedge where valid&ready.
   logic [10:0] u_log[$];
   int          u_log_cyc[$];
   logic [10:0] s_log[$];
   always @(negedge clk) begin
      if (rst === 1'b0 && u_ovalid === 1'b1 && u_oready === 1'b1) begin
         u_log.push_back(u_out);
         u_log_cyc.push_back(cyc);
      end
      if (rst === 1'b0 && s_ovalid === 1'b1 && s_oready === 1'b1) s_log.push_back(s_out);
   end

   function automatic logic [10:0] sum_u(input logic [63:0] d);
      int s = 0;
      for (int k = 0; k < 8; k++) s += int'(d[k*8 +: 8]);
      return 11'(s);
   endfunction

   function automatic logic [10:0] sum_s(input logic [63:0] d);
      int s = 0;
      for (int k = 0; k < 8; k++) s += int'($signed(d[k*8 +: 8]));
      return 11'(s);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      u_data = '0; u_valid = 0; u_last = 0; u_oready = 1;
      s_data = '0; s_valid = 0; s_last = 0; s_oready = 1;
      a_data = '0; a_valid = 0; a_last = 0; a_oready = 1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (u_ovalid !== 1'b0) $display("FAIL reset_u_valid: got %b want 0", u_ovalid); else n_pass++;
      n_checks++; if (s_ovalid !== 1'b0) $display("FAIL reset_s_valid: got %b want 0", s_ovalid); else n_pass++;
      n_checks++; if (a_ovalid !== 1'b0) $display("FAIL reset_a_valid: got %b want 0", a_ovalid); else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (u_ready !== 1'b1) $display("FAIL reset_u_ready: got %b want 1", u_ready); else n_pass++;
      n_checks++; if (u_ovalid !== 1'b0) $display("FAIL post_reset_u_valid: got %b want 0", u_ovalid); else n_pass++;
   endtask

   task automatic test_all_ones();
      u_data = {8{8'hFF}}; u_valid = 1;
      @(posedge clk); #1;
      u_valid = 0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (u_ovalid !== (k == 4)) $display("FAIL ones_latency k=%0d: got %b want %b", k, u_ovalid, (k == 4));
         else n_pass++;
         if (k == 4) begin
            n_checks++;
            if (u_out !== 11'd2040) $display("FAIL ones_sum: got %0d want 2040", u_out); else n_pass++;
         end
      end
   endtask

   task automatic test_signed_beat(input logic [63:0] d, input logic [10:0] exp, input string name);
      s_data = d; s_valid = 1;
      @(posedge clk); #1;
      s_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (s_ovalid !== 1'b0) $display("FAIL %s_early: got %b want 0", name, s_ovalid); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (s_ovalid !== 1'b1) $display("FAIL %s_valid: got %b want 1", name, s_ovalid); else n_pass++;
      n_checks++; if (s_out !== exp) $display("FAIL %s_sum: got %h want %h", name, s_out, exp); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp[$];
      logic [63:0] d;
      u_log.delete(); u_log_cyc.delete();
      for (int i = 0; i < 16; i++) begin
         d = {$urandom, $urandom};
         exp.push_back(sum_u(d));
         u_data = d; u_valid = 1;
         @(negedge clk);
         n_checks++; if (u_ready !== 1'b1) $display("FAIL b2b_ready beat %0d: got %b want 1", i, u_ready); else n_pass++;
         @(posedge clk); #1;
      end
      u_valid = 0;
      for (int t = 0; t < 50 && u_log.size() < 16; t++) @(posedge clk);
      #1;
      n_checks++; if (u_log.size() != 16) $display("FAIL b2b_count: got %0d want 16", u_log.size()); else n_pass++;
      for (int i = 0; i < 16 && i < u_log.size(); i++) begin
         n_checks++;
         if (u_log[i] !== exp[i]) $display("FAIL b2b_sum %0d: got %0d want %0d", i, u_log[i], exp[i]); else n_pass++;
      end
      if (u_log_cyc.size() == 16) begin
         n_checks++;
         if (u_log_cyc[15] - u_log_cyc[0] != 15)
            $display("FAIL b2b_rate: got %0d cycles want 15", u_log_cyc[15] - u_log_cyc[0]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] beats[12];
      logic [10:0] exp[$];
      u_log.delete(); u_log_cyc.delete();
      for (int i = 0; i < 12; i++) begin
         beats[i] = {$urandom, $urandom};
         exp.push_back(sum_u(beats[i]));
      end
      fork
         begin
            int i = 0;
            int guard = 0;
            logic took;
            while (i < 12 && guard < 200) begin
               u_data = beats[i]; u_valid = 1;
               @(negedge clk);
               took = u_ready;
               @(posedge clk); #1;
               if (took) i++;
               guard++;
            end
            u_valid = 0;
         end
         begin
            logic [10:0] held;
            for (int t = 0; t < 50; t++) begin
               @(negedge clk);
               if (u_ovalid) break;
            end
            @(posedge clk); #1;
            u_oready = 0;
            @(negedge clk);
            held = u_out;
            for (int k = 0; k < 5; k++) begin
               if (k > 0) @(negedge clk);
               n_checks++; if (u_ovalid !== 1'b1) $display("FAIL bp_hold_valid %0d: got %b want 1", k, u_ovalid); else n_pass++;
               n_checks++; if (u_out !== held) $display("FAIL bp_hold_data %0d: got %0d want %0d", k, u_out, held); else n_pass++;
               n_checks++; if (u_ready !== 1'b0) $display("FAIL bp_in_ready %0d: got %b want 0", k, u_ready); else n_pass++;
            end
            @(posedge clk); #1;
            u_oready = 1;
         end
      join
      for (int t = 0; t < 60 && u_log.size() < 12; t++) @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      n_checks++; if (u_log.size() != 12) $display("FAIL bp_count: got %0d want 12", u_log.size()); else n_pass++;
      for (int i = 0; i < 12 && i < u_log.size(); i++) begin
         n_checks++;
         if (u_log[i] !== exp[i]) $display("FAIL bp_sum %0d: got %0d want %0d", i, u_log[i], exp[i]); else n_pass++;
      end
   endtask

   task automatic test_signed_random();
      logic [10:0] exp[$];
      logic [63:0] d;
      s_log.delete();
      for (int i = 0; i < 8; i++) begin
         d = {$urandom, $urandom};
         exp.push_back(sum_s(d));
         s_data = d; s_valid = 1;
         @(posedge clk); #1;
      end
      s_valid = 0;
      for (int t = 0; t < 50 && s_log.size() < 8; t++) @(posedge clk);
      #1;
      n_checks++; if (s_log.size() != 8) $display("FAIL srand_count: got %0d want 8", s_log.size()); else n_pass++;
      for (int i = 0; i < 8 && i < s_log.size(); i++) begin
         n_checks++;
         if (s_log[i] !== exp[i]) $display("FAIL srand_sum %0d: got %h want %h", i, s_log[i], exp[i]); else n_pass++;
      end
   endtask

   // Drives one frame (every operand of beat i = vals[i]) and expects one result LEVELS+2 after the last beat.
   task automatic run_frame(input byte unsigned vals[$], input string name);
      logic [18:0] exp;
      int n;
      exp = '0;
      n = vals.size();
      foreach (vals[i]) exp = exp + 19'(8 * int'(vals[i]));
      a_oready = 1;
      for (int i = 0; i < n; i++) begin
         a_data = {8{vals[i]}}; a_last = (i == n - 1); a_valid = 1;
         @(negedge clk);
         n_checks++; if (a_ready !== 1'b1) $display("FAIL %s_ready beat %0d: got %b want 1", name, i, a_ready); else n_pass++;
         n_checks++; if (a_ovalid !== 1'b0) $display("FAIL %s_stray beat %0d: got %b want 0", name, i, a_ovalid); else n_pass++;
         @(posedge clk); #1;
      end
      a_valid = 0; a_last = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (a_ovalid !== (k == 5)) $display("FAIL %s_latency k=%0d: got %b want %b", name, k, a_ovalid, (k == 5));
         else n_pass++;
         if (k == 5) begin
            n_checks++;
            if (a_out !== exp) $display("FAIL %s_sum: got %0d want %0d", name, a_out, exp); else n_pass++;
         end
      end
   endtask

   task automatic test_accumulate();
      byte unsigned v[$];
      v = '{8'd1, 8'd2, 8'd3};
      run_frame(v, "acc123");
      v = '{8'd1};
      run_frame(v, "acc_single");
      for (int f = 0; f < 3; f++) begin
         v.delete();
         for (int i = 0; i < int'($urandom_range(1, 4)); i++) v.push_back(8'($urandom));
         run_frame(v, "acc_rand");
      end
      // 260 beats of 2040 overflow the 19-bit accumulator once
      v.delete();
      for (int i = 0; i < 260; i++) v.push_back(8'hFF);
      run_frame(v, "acc_wrap");
   endtask

   task automatic test_reset_mid_frame();
      byte unsigned v[$];
      a_oready = 1;
      a_data = {8{8'd2}}; a_last = 1; a_valid = 1;
      @(posedge clk); #1;
      a_data = {8{8'd5}}; a_last = 0;
      repeat (2) @(posedge clk);
      #1;
      a_valid = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (a_ovalid) break;
      end
      a_oready = 0;
      n_checks++; if (a_ovalid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", a_ovalid); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (a_ovalid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", a_ovalid); else n_pass++;
      n_checks++; if (a_ready !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", a_ready); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      a_oready = 1;
      v = '{8'd1, 8'd1};
      run_frame(v, "acc_after_rst");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_all_ones();
      test_signed_beat({8{8'h80}}, 11'h400, "signed_min");
      test_signed_beat(64'h807F_807F_807F_807F, 11'h7FC, "signed_alt");
      test_back_to_back();
      test_backpressure();
      test_signed_random();
      test_accumulate();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
